// File: rtl/usina_pkg.sv
// usina_pkg: reactor supervisor state type, default limits and the shared sensor-limit check.
package usina_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ALERTA   = 2'd1,
        SCRAM    = 2'd2,
        RECUPERA = 2'd3
    } estado_t;

    localparam int unsigned LIMITE_TEMP_DEF     = 40;
    localparam int unsigned LIMITE_PRESSAO_DEF  = 7;
    localparam int unsigned LIMITE_RAD_DEF      = 1000;
    localparam int unsigned LIMITE_RAD_CRIT_DEF = 2000;
    localparam int unsigned N_CONFIRMA_DEF      = 4;
    localparam int unsigned T_ALERTA_DEF        = 64;
    localparam int unsigned T_BARRA_DEF         = 16;
    localparam int unsigned N_BARRAS_DEF        = 8;

    // Limits default to the plant values so the control-room alarm can call it with three args.
    function automatic logic excede_limite(
        input logic [7:0]  temp,
        input logic [3:0]  pressao,
        input logic [11:0] radiacao,
        input int unsigned lim_temp    = LIMITE_TEMP_DEF,
        input int unsigned lim_pressao = LIMITE_PRESSAO_DEF,
        input int unsigned lim_rad     = LIMITE_RAD_DEF
    );
        return (32'(temp) > lim_temp) | (32'(pressao) >= lim_pressao) |
               (32'(radiacao) >= lim_rad);
    endfunction

endpackage

// File: rtl/acionador_barras.sv
// acionador_barras: rod-drive stepper; one rod step every T_BARRA cycles while inserting or
// withdrawing, position saturating at 0 and N_BARRAS.
module acionador_barras #(
    parameter int unsigned T_BARRA  = 16,
    parameter int unsigned N_BARRAS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inserir,
    input  logic                          retirar,
    input  logic                          limpa,
    output logic [$clog2(N_BARRAS+1)-1:0] posBarras,
    output logic                          barraMovendo
);

    localparam int unsigned PW = $clog2(N_BARRAS + 1);
    localparam int unsigned TW = (T_BARRA > 1) ? $clog2(T_BARRA) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(N_BARRAS);
    localparam logic [TW-1:0] TMR_MAX = TW'(T_BARRA - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          mov_q, mov_d;

    // A state change restarts the step period and suppresses any step due that cycle.
    always_comb begin
        tmr_d = tmr_q;
        pos_d = pos_q;
        mov_d = 1'b0;
        if (limpa) begin
            tmr_d = '0;
        end else if (inserir || retirar) begin
            if (tmr_q == TMR_MAX) begin
                tmr_d = '0;
                if (inserir && (pos_q != POS_MAX)) begin
                    pos_d = pos_q + 1'b1;
                    mov_d = 1'b1;
                end else if (retirar && (pos_q != '0)) begin
                    pos_d = pos_q - 1'b1;
                    mov_d = 1'b1;
                end
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            pos_q <= '0;
            mov_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            pos_q <= pos_d;
            mov_q <= mov_d;
        end
    end

    assign posBarras    = pos_q;
    assign barraMovendo = mov_q;

endmodule

// File: rtl/controle_desligamento.sv
// controle_desligamento: reactor-core supervisor escalating NORMAL -> ALERTA -> SCRAM on confirmed
// sensor violations. Defining CONTADOR_SCRAM_EN adds the numScram entry counter output.
module controle_desligamento
    import usina_pkg::*;
#(
    parameter int unsigned LIMITE_TEMP     = LIMITE_TEMP_DEF,
    parameter int unsigned LIMITE_PRESSAO  = LIMITE_PRESSAO_DEF,
    parameter int unsigned LIMITE_RAD      = LIMITE_RAD_DEF,
    parameter int unsigned LIMITE_RAD_CRIT = LIMITE_RAD_CRIT_DEF,
    parameter int unsigned N_CONFIRMA      = N_CONFIRMA_DEF,
    parameter int unsigned T_ALERTA        = T_ALERTA_DEF,
    parameter int unsigned T_BARRA         = T_BARRA_DEF,
    parameter int unsigned N_BARRAS        = N_BARRAS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    temp,
    input  logic [3:0]                    pressao,
    input  logic [11:0]                   radiacao,
    input  logic                          amostraValida,
    input  logic                          reconhece,
    input  logic                          rearme,
    output logic                          alarmeSonoro,
    output logic                          scram,
    output logic [1:0]                    estado,
    output logic [$clog2(N_BARRAS+1)-1:0] posBarras,
    output logic                          barraMovendo
`ifdef CONTADOR_SCRAM_EN
    ,
    output logic [7:0]                    numScram
`endif
);

    localparam int unsigned CW = $clog2(N_CONFIRMA + 1);
    localparam int unsigned AW = (T_ALERTA > 1) ? $clog2(T_ALERTA) : 1;
    localparam int unsigned PW = $clog2(N_BARRAS + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(N_CONFIRMA);
    localparam logic [AW-1:0] ALERTA_MAX = AW'(T_ALERTA - 1);
    localparam logic [PW-1:0] POS_MAX    = PW'(N_BARRAS);

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_viol_q, cnt_viol_d;
    logic [CW-1:0] cnt_limpo_q, cnt_limpo_d;
    logic [AW-1:0] alerta_tmr_q, alerta_tmr_d;
    logic          silencio_q, silencio_d;
    logic          alarme_q, alarme_d;
    logic          scram_q, scram_d;
    logic          viol, crit, entra;

    assign viol = amostraValida &
                  excede_limite(temp, pressao, radiacao, LIMITE_TEMP, LIMITE_PRESSAO, LIMITE_RAD);
    assign crit = amostraValida & (32'(radiacao) >= LIMITE_RAD_CRIT);

    // Confirmation counters only move on valid samples; timers are handled separately.
    always_comb begin
        cnt_viol_d  = cnt_viol_q;
        cnt_limpo_d = cnt_limpo_q;
        if (amostraValida) begin
            if (viol) begin
                cnt_limpo_d = '0;
                if (cnt_viol_q != CNT_MAX) cnt_viol_d = cnt_viol_q + 1'b1;
            end else begin
                cnt_viol_d = '0;
                if (cnt_limpo_q != CNT_MAX) cnt_limpo_d = cnt_limpo_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (crit)                        state_d = SCRAM;
                else if (cnt_viol_d == CNT_MAX)  state_d = ALERTA;
            end
            ALERTA: begin
                if (crit)                            state_d = SCRAM;
                else if (cnt_limpo_d == CNT_MAX)     state_d = NORMAL;
                else if (alerta_tmr_q == ALERTA_MAX) state_d = SCRAM;
            end
            SCRAM: begin
                if ((posBarras == POS_MAX) && rearme && (cnt_limpo_d == CNT_MAX)) begin
                    state_d = RECUPERA;
                end
            end
            RECUPERA: begin
                if (viol)                  state_d = SCRAM;
                else if (posBarras == '0)  state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    assign entra = (state_d != state_q);

    always_comb begin
        alerta_tmr_d = alerta_tmr_q;
        if (entra) begin
            alerta_tmr_d = '0;
        end else if ((state_q == ALERTA) && (alerta_tmr_q != ALERTA_MAX)) begin
            alerta_tmr_d = alerta_tmr_q + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with estado.
    always_comb begin
        silencio_d = silencio_q;
        if (entra) begin
            silencio_d = 1'b0;
        end else if ((state_q == ALERTA) && reconhece) begin
            silencio_d = 1'b1;
        end
        alarme_d = (state_d == SCRAM) | ((state_d == ALERTA) & ~silencio_d);
        scram_d  = (state_d == SCRAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= NORMAL;
            cnt_viol_q   <= '0;
            cnt_limpo_q  <= '0;
            alerta_tmr_q <= '0;
            silencio_q   <= 1'b0;
            alarme_q     <= 1'b0;
            scram_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_viol_q   <= cnt_viol_d;
            cnt_limpo_q  <= cnt_limpo_d;
            alerta_tmr_q <= alerta_tmr_d;
            silencio_q   <= silencio_d;
            alarme_q     <= alarme_d;
            scram_q      <= scram_d;
        end
    end

    assign estado       = state_q;
    assign alarmeSonoro = alarme_q;
    assign scram        = scram_q;

    acionador_barras #(
        .T_BARRA  (T_BARRA),
        .N_BARRAS (N_BARRAS)
    ) u_barras (
        .clk          (clk),
        .rst_n        (rst_n),
        .inserir      (state_q == SCRAM),
        .retirar      (state_q == RECUPERA),
        .limpa        (entra),
        .posBarras    (posBarras),
        .barraMovendo (barraMovendo)
    );

`ifdef CONTADOR_SCRAM_EN
    logic [7:0] num_scram_q, num_scram_d;

    always_comb begin
        num_scram_d = num_scram_q;
        if (entra && (state_d == SCRAM) && (num_scram_q != 8'hFF)) begin
            num_scram_d = num_scram_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) num_scram_q <= '0;
        else        num_scram_q <= num_scram_d;
    end

    assign numScram = num_scram_q;
`endif

endmodule

// File: tb/tb_controle_desligamento.sv
// tb_controle_desligamento: table vectors, directed multi-cycle sequences and random stimulus
// checked against a cycle-level behavioural model of the supervisor.
module tb_controle_desligamento;

    localparam int LIM_T = 40;
    localparam int LIM_P = 7;
    localparam int LIM_R = 1000;
    localparam int LIM_C = 2000;
    localparam int NC    = 4;
    localparam int TA    = 64;
    localparam int TB    = 16;
    localparam int NB    = 8;

    localparam int E_NORMAL   = 0;
    localparam int E_ALERTA   = 1;
    localparam int E_SCRAM    = 2;
    localparam int E_RECUPERA = 3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  temp;
    logic [3:0]  pressao;
    logic [11:0] radiacao;
    logic        amostraValida;
    logic        reconhece;
    logic        rearme;
    logic        alarmeSonoro;
    logic        scram;
    logic [1:0]  estado;
    logic [3:0]  posBarras;
    logic        barraMovendo;
`ifdef CONTADOR_SCRAM_EN
    logic [7:0]  numScram;
`endif

    controle_desligamento dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .temp          (temp),
        .pressao       (pressao),
        .radiacao      (radiacao),
        .amostraValida (amostraValida),
        .reconhece     (reconhece),
        .rearme        (rearme),
        .alarmeSonoro  (alarmeSonoro),
        .scram         (scram),
        .estado        (estado),
        .posBarras     (posBarras),
        .barraMovendo  (barraMovendo)
`ifdef CONTADOR_SCRAM_EN
        ,
        .numScram      (numScram)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ciclo_n = 0;

    // Model: state, confirmation counts, cycles since entering the state, rods, buzzer silence.
    int m_est, m_cv, m_cl, m_nesse, m_pos, m_mov, m_sil, m_alarm, m_scram, m_nscram;

    task automatic modelo_reset();
        m_est = E_NORMAL; m_cv = 0; m_cl = 0; m_nesse = 0; m_pos = 0; m_mov = 0;
        m_sil = 0; m_alarm = 0; m_scram = 0; m_nscram = 0;
    endtask

    task automatic modelo(input logic v, input logic [7:0] t, input logic [3:0] p,
                          input logic [11:0] r, input logic rec, input logic rea);
        int  ti, pi, ri, prox;
        bit  vi, cr;
        ti = int'(t);
        pi = int'(p);
        ri = int'(r);
        vi = v && (ti > LIM_T || pi >= LIM_P || ri >= LIM_R);
        cr = v && (ri >= LIM_C);
        if (v && vi) begin
            m_cv = (m_cv >= NC) ? NC : m_cv + 1;
            m_cl = 0;
        end else if (v) begin
            m_cl = (m_cl >= NC) ? NC : m_cl + 1;
            m_cv = 0;
        end
        case (m_est)
            E_NORMAL: prox = cr ? E_SCRAM : (m_cv == NC) ? E_ALERTA : E_NORMAL;
            E_ALERTA: prox = cr ? E_SCRAM : (m_cl == NC) ? E_NORMAL :
                             (m_nesse == TA - 1) ? E_SCRAM : E_ALERTA;
            E_SCRAM:  prox = (m_pos == NB && rea && m_cl == NC) ? E_RECUPERA : E_SCRAM;
            default:  prox = vi ? E_SCRAM : (m_pos == 0) ? E_NORMAL : E_RECUPERA;
        endcase
        m_mov = 0;
        if (prox != m_est) begin
            m_nesse = 0;
            m_sil   = 0;
            if (prox == E_SCRAM && m_nscram < 255) m_nscram++;
        end else begin
            if (m_est == E_ALERTA && rec) m_sil = 1;
            // Rods step once per TB cycles spent in SCRAM/RECUPERA.
            if (m_est >= E_SCRAM && (m_nesse % TB) == TB - 1) begin
                if (m_est == E_SCRAM && m_pos < NB) begin m_pos++; m_mov = 1; end
                if (m_est == E_RECUPERA && m_pos > 0) begin m_pos--; m_mov = 1; end
            end
            m_nesse++;
        end
        m_est   = prox;
        m_alarm = (m_est == E_SCRAM || (m_est == E_ALERTA && !m_sil)) ? 1 : 0;
        m_scram = (m_est == E_SCRAM) ? 1 : 0;
    endtask

    task automatic verifica(input string nome, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nome, ciclo_n, got, exp);
        end
    endtask

    task automatic compara();
        verifica("estado", int'(estado), m_est);
        verifica("posBarras", int'(posBarras), m_pos);
        verifica("barraMovendo", int'(barraMovendo), m_mov);
        verifica("alarmeSonoro", int'(alarmeSonoro), m_alarm);
        verifica("scram", int'(scram), m_scram);
`ifdef CONTADOR_SCRAM_EN
        verifica("numScram", int'(numScram), m_nscram);
`endif
    endtask

    task automatic ciclo(input logic v, input logic [7:0] t, input logic [3:0] p,
                         input logic [11:0] r, input logic rec, input logic rea);
        amostraValida = v; temp = t; pressao = p; radiacao = r; reconhece = rec; rearme = rea;
        modelo(v, t, p, r, rec, rea);
        @(posedge clk);
        #1;
        ciclo_n++;
        compara();
    endtask

    task automatic limpo(input logic rea);
        ciclo(1'b1, 8'd30, 4'd3, 12'd500, 1'b0, rea);
    endtask

    task automatic aplica_reset();
        rst_n = 1'b0;
        amostraValida = 1'b0; temp = '0; pressao = '0; radiacao = '0;
        reconhece = 1'b0; rearme = 1'b0;
        modelo_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  t;
        logic [3:0]  p;
        logic [11:0] r;
        logic        rec;
        logic        rea;
        int          e_est;
        int          e_al;
        int          e_sc;
        int          e_pos;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] t, input logic [3:0] p,
                                input logic [11:0] r, input logic rec, input logic rea,
                                input int e_est, input int e_al, input int e_sc);
        vec_t x;
        x.v = v; x.t = t; x.p = p; x.r = r; x.rec = rec; x.rea = rea;
        x.e_est = e_est; x.e_al = e_al; x.e_sc = e_sc; x.e_pos = 0;
        return x;
    endfunction

    localparam int NV = 19;
    vec_t tab [NV];

    initial begin
        int pulsos;
        int guarda;
        int modo;
        int resto;
        int pv;
        logic        v, rec, rea;
        logic [7:0]  t;
        logic [3:0]  p;
        logic [11:0] r;

        tab[0]  = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[1]  = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[2]  = mk(1'b1, 8'd41, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[3]  = mk(1'b1, 8'd41, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[4]  = mk(1'b1, 8'd41, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[5]  = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[6]  = mk(1'b1, 8'd41, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[7]  = mk(1'b1, 8'd40, 4'd7, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[8]  = mk(1'b1, 8'd30, 4'd6, 12'd1000, 1'b0, 1'b0, 0, 0, 0);
        tab[9]  = mk(1'b1, 8'd41, 4'd3, 12'd999,  1'b0, 1'b0, 1, 1, 0);
        tab[10] = mk(1'b0, 8'd41, 4'd3, 12'd500,  1'b0, 1'b0, 1, 1, 0);
        tab[11] = mk(1'b0, 8'd30, 4'd3, 12'd500,  1'b1, 1'b0, 1, 0, 0);
        tab[12] = mk(1'b1, 8'd41, 4'd3, 12'd500,  1'b0, 1'b0, 1, 0, 0);
        tab[13] = mk(1'b1, 8'd40, 4'd6, 12'd999,  1'b0, 1'b0, 1, 0, 0);
        tab[14] = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b0, 1, 0, 0);
        tab[15] = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b0, 1, 0, 0);
        tab[16] = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b0, 0, 0, 0);
        tab[17] = mk(1'b1, 8'd30, 4'd3, 12'd2000, 1'b0, 1'b0, 2, 1, 1);
        tab[18] = mk(1'b1, 8'd30, 4'd3, 12'd500,  1'b0, 1'b1, 2, 1, 1);

        aplica_reset();
        compara();
        verifica("reset.estado", int'(estado), 0);
        verifica("reset.posBarras", int'(posBarras), 0);

        repeat (20) limpo(1'b0);
        verifica("limpo.estado", int'(estado), 0);
        verifica("limpo.alarme", int'(alarmeSonoro), 0);

        for (int i = 0; i < NV; i++) begin
            ciclo(tab[i].v, tab[i].t, tab[i].p, tab[i].r, tab[i].rec, tab[i].rea);
            verifica("tab.estado", int'(estado), tab[i].e_est);
            verifica("tab.alarme", int'(alarmeSonoro), tab[i].e_al);
            verifica("tab.scram", int'(scram), tab[i].e_sc);
            verifica("tab.posBarras", int'(posBarras), tab[i].e_pos);
        end

        // Full insertion: one step per 16 cycles, stop at 8.
        pulsos = 0;
        guarda = 0;
        while (m_pos < NB && guarda < 200) begin
            limpo(1'b0);
            if (barraMovendo) pulsos++;
            guarda++;
        end
        repeat (20) begin
            limpo(1'b0);
            if (barraMovendo) pulsos++;
        end
        verifica("insercao.pos", int'(posBarras), 8);
        verifica("insercao.pulsos", pulsos, 8);
        verifica("insercao.estado", int'(estado), 2);

        limpo(1'b1);
        verifica("rearme.estado", int'(estado), 3);
        verifica("rearme.scram", int'(scram), 0);
        verifica("rearme.alarme", int'(alarmeSonoro), 0);

        guarda = 0;
        while (m_pos != 5 && guarda < 100) begin limpo(1'b0); guarda++; end
        verifica("recupera.pos5", int'(posBarras), 5);
        ciclo(1'b1, 8'd41, 4'd3, 12'd500, 1'b0, 1'b0);
        verifica("recupera.viol.estado", int'(estado), 2);
        verifica("recupera.viol.pos", int'(posBarras), 5);
        repeat (15) limpo(1'b0);
        verifica("retoma.pos5", int'(posBarras), 5);
        limpo(1'b0);
        verifica("retoma.pos6", int'(posBarras), 6);

        guarda = 0;
        while (m_pos < NB && guarda < 200) begin limpo(1'b0); guarda++; end
        guarda = 0;
        while (m_est != E_RECUPERA && guarda < 10) begin limpo(1'b1); guarda++; end
        guarda = 0;
        while (m_est != E_NORMAL && guarda < 200) begin limpo(1'b0); guarda++; end
        verifica("retirada.estado", int'(estado), 0);
        verifica("retirada.pos", int'(posBarras), 0);

        // ALERTA timeout with pressure held at the limit.
        repeat (4) ciclo(1'b1, 8'd30, 4'd7, 12'd500, 1'b0, 1'b0);
        verifica("alerta.estado", int'(estado), 1);
        repeat (63) ciclo(1'b1, 8'd30, 4'd7, 12'd500, 1'b0, 1'b0);
        verifica("alerta.63.estado", int'(estado), 1);
        ciclo(1'b1, 8'd30, 4'd7, 12'd500, 1'b0, 1'b0);
        verifica("timeout.estado", int'(estado), 2);
        verifica("timeout.scram", int'(scram), 1);
        ciclo(1'b1, 8'd30, 4'd7, 12'd500, 1'b1, 1'b0);
        verifica("scram.reconhece.alarme", int'(alarmeSonoro), 1);

        guarda = 0;
        while (m_pos < 4 && guarda < 100) begin
            ciclo(1'b1, 8'd30, 4'd7, 12'd500, 1'b0, 1'b0);
            guarda++;
        end
        verifica("meio.pos4", int'(posBarras), 4);
`ifdef CONTADOR_SCRAM_EN
        verifica("numScram.3", int'(numScram), 3);
`endif

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        verifica("async.estado", int'(estado), 0);
        verifica("async.pos", int'(posBarras), 0);
        verifica("async.mov", int'(barraMovendo), 0);
        verifica("async.alarme", int'(alarmeSonoro), 0);
        verifica("async.scram", int'(scram), 0);
`ifdef CONTADOR_SCRAM_EN
        verifica("async.numScram", int'(numScram), 0);
`endif
        aplica_reset();
        compara();

        // Random regimes: clean, mostly clean, and violation-heavy.
        modo  = 0;
        resto = 0;
        for (int i = 0; i < 6000; i++) begin
            if (resto == 0) begin
                modo  = int'($urandom_range(0, 2));
                resto = int'($urandom_range(20, 300));
            end
            resto--;
            v   = ($urandom_range(0, 99) < 85);
            t   = 8'($urandom_range(0, 40));
            p   = 4'($urandom_range(0, 6));
            r   = 12'($urandom_range(0, 999));
            pv  = (modo == 0) ? 0 : (modo == 1) ? 4 : 55;
            if (int'($urandom_range(0, 99)) < pv) begin
                case ($urandom_range(0, 3))
                    0: t = ($urandom_range(0, 1) == 1) ? 8'd41 : 8'($urandom_range(41, 255));
                    1: p = ($urandom_range(0, 1) == 1) ? 4'd7 : 4'($urandom_range(7, 15));
                    2: r = ($urandom_range(0, 1) == 1) ? 12'd1000 : 12'($urandom_range(1000, 1999));
                    default: r = ($urandom_range(0, 3) == 0) ? 12'd2000 :
                                 12'($urandom_range(1999, 4095));
                endcase
            end
            rec = ($urandom_range(0, 4) == 0);
            rea = ($urandom_range(0, 2) == 0);
            ciclo(v, t, p, r, rec, rea);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_desligamento.md
Name: controle_desligamento

Overview:
- Sequential supervisor for the reactor core. It samples the temperature, pressure and radiation sensor buses and confirms limit violations over several samples.
- Escalates NORMAL -> ALERTA -> SCRAM. It drives control-rod insertion and withdrawal stepwise and feeds the control-room buzzer and status panel.
- Sits between the sensor front-end and the rod-drive actuator.

Parameters:
- LIMITE_TEMP, 40, violation when temp > value.
- LIMITE_PRESSAO, 7, violation when pressao >= value.
- LIMITE_RAD, 1000, violation when radiacao >= value.
- LIMITE_RAD_CRIT, 2000, critical; immediate SCRAM when radiacao >= value.
- N_CONFIRMA, 4, consecutive valid samples needed to confirm a violation, or to confirm clearance.
- T_ALERTA, 64, cycles allowed in ALERTA before forced SCRAM.
- T_BARRA, 16, cycles per rod step.
- N_BARRAS, 8, fully-inserted rod position.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- temp  in  8  unsigned temperature.
- pressao  in  4  unsigned pressure.
- radiacao  in  12  unsigned radiation.
- amostraValida  in  1  sensor buses valid this cycle.
- reconhece  in  1  operator acknowledge, level.
- rearme  in  1  operator re-arm request, level.
- alarmeSonoro  out  1  buzzer.
- scram  out  1  emergency shutdown active.
- estado  out  2  0=NORMAL 1=ALERTA 2=SCRAM 3=RECUPERA.
- posBarras  out  $clog2(N_BARRAS+1)  rod position, 0=withdrawn.
- barraMovendo  out  1  one-cycle pulse on each rod step.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n=0 immediately forces estado=NORMAL, posBarras=0, all counters 0, alarmeSonoro=0, scram=0, barraMovendo=0.
- All outputs are registered.
- viol = (temp>LIMITE_TEMP) | (pressao>=LIMITE_PRESSAO) | (radiacao>=LIMITE_RAD). All comparisons are unsigned.
- crit = radiacao>=LIMITE_RAD_CRIT. viol and crit are evaluated only when amostraValida=1. Cycles with amostraValida=0 hold every counter except the timers.
- cntViol: +1 on a valid sample with viol=1, cleared on a valid sample with viol=0. Saturates at N_CONFIRMA.
- cntLimpo: the mirror of cntViol (+1 on valid viol=0, cleared on valid viol=1). Saturates at N_CONFIRMA.
- NORMAL:
  - crit -> SCRAM next cycle.
  - Otherwise cntViol reaching N_CONFIRMA (the sample that makes it N_CONFIRMA) -> ALERTA. Latency from the first violating sample is N_CONFIRMA valid samples + 1 cycle.
- ALERTA:
  - Timer counts every cycle from 0.
  - Buzzer is 1 until reconhece=1 is seen, then silenced for the rest of this ALERTA visit.
  - cntLimpo==N_CONFIRMA -> NORMAL.
  - crit, or timer==T_ALERTA-1 with cntLimpo<N_CONFIRMA -> SCRAM.
  - If crit and clearance coincide, crit wins.
- SCRAM:
  - scram=1 and alarmeSonoro=1; reconhece is ignored.
  - Step timer counts to T_BARRA-1, then posBarras+1 with a barraMovendo pulse, until posBarras==N_BARRAS. No overshoot.
  - Exit to RECUPERA only when posBarras==N_BARRAS, rearme=1 and cntLimpo==N_CONFIRMA. rearme at any other time is ignored.
- RECUPERA:
  - scram=0, alarmeSonoro=0.
  - Every T_BARRA cycles posBarras-1 with a pulse. At posBarras==0 -> NORMAL.
  - Any valid sample with viol=1 -> SCRAM. Insertion resumes from the current position, the step timer restarts at 0, and there is no jump to N_BARRAS.
- State entry: step timer and ALERTA timer clear on every state entry. cntViol and cntLimpo persist across states.
- Reset mid-motion: rods report 0 immediately. The actuator recalibrates on its own.

Optional Feature:
- Macro CONTADOR_SCRAM_EN.
- When defined: adds output numScram (8 bits, reset 0). It increments on every entry into SCRAM, from NORMAL, ALERTA or RECUPERA, and saturates at 255.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package usina_pkg holds:
  - enum estado_t: NORMAL, ALERTA, SCRAM, RECUPERA (2 bits).
  - Default threshold constants.
  - Function excede_limite(temp, pressao, radiacao), shared with the control-room alarm logic.
- One sub-module, acionador_barras: step timer plus up/down rod position counter with saturation. Inputs: inserir, retirar. Outputs: posBarras, barraMovendo.

Test Plan:
- Reset then valid samples temp=30 p=3 rad=500 for 20 cycles -> estado=0, alarmeSonoro=0, posBarras=0.
- 4 consecutive valid samples with temp=41 -> estado=1 on the cycle after the 4th. 3 violations then one clean sample -> stays 0.
- In ALERTA, assert reconhece -> alarmeSonoro=0, estado stays 1. Then feed 4 clean samples -> estado=0.
- In ALERTA with pressao=7 held for 64 cycles -> estado=2, scram=1. posBarras rises by 1 every 16 cycles and stops at 8.
- From NORMAL, one valid sample with rad=2000 -> estado=2 next cycle. At posBarras=8 with clean samples and rearme=1 -> estado=3; rods withdraw to 0 -> estado=0. Repeat with a violation at posBarras=5 in RECUPERA -> estado=2 and insertion resumes from 5.
- Assert rst_n=0 mid-SCRAM at posBarras=4 -> all outputs 0 immediately, asynchronously. With CONTADOR_SCRAM_EN defined, numScram is 0 after reset and 2 after two SCRAM entries.
